dram_ctrl: RTL and testbench



---
 rtl/dram_ctrl_if.sv | 28 ++
 rtl/dram_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_dram_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dram_ctrl_if.sv
// dram_ctrl_if -- requester-side bus of the DRAM controller.
//   req    : access request, held high by the requester until ack
//   write  : 1 = write, 0 = read (valid with req)
//   addr   : 21-bit word address, row = addr[20:10], col = addr[9:0]
//   wdata  : write data (valid with req)
//   ack    : one-cycle completion pulse
//   rdata  : read data, valid with ack on reads, held until the next read
//   busy   : controller is not idle
// master = requester side, slave = controller side.
interface dram_ctrl_if;
  logic        req;
  logic        write;
  logic [20:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        busy;

  modport master (
    output req, write, addr, wdata,
    input  ack, rdata, busy
  );

  modport slave (
    input  req, write, addr, wdata,
    output ack, rdata, busy
  );
endinterface

// File: rtl/dram_ctrl.sv
// dram_ctrl -- single-bank DRAM controller with open-row policy.
// Keeps the last activated row open so that accesses to the same row skip
// precharge/activate. An open row that sees no request for IDLE_CLOSE
// cycles is closed automatically with a precharge.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : requester handshake (req/write/addr/wdata/ack/rdata/busy)
//   DRAM_Q            : read data from the DRAM
//   DRAM_CSn/RASn/CASn/WEn : active-low DRAM strobes (registered)
//   DRAM_A            : multiplexed row/column address (registered)
//   DRAM_D            : write data to the DRAM (registered)
module dram_ctrl #(
  parameter int T_RP       = 2,
  parameter int T_RCD      = 2,
  parameter int T_CL       = 3,
  parameter int T_WR       = 2,
  parameter int IDLE_CLOSE = 16
) (
  input  logic        clk,
  input  logic        rst,
  dram_ctrl_if.slave  bus,
  input  logic [31:0] DRAM_Q,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic        DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D
);

  localparam int MAX_AB = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int MAX_CD = (T_CL > T_WR) ? T_CL : T_WR;
  localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_T + 1);
  localparam int IW     = $clog2(IDLE_CLOSE + 1);

  // The state counter is loaded with (duration - 1) on entry and the state
  // ends on the cycle it reads zero.
  localparam logic [CW-1:0] CNT_RP  = CW'(T_RP - 1);
  localparam logic [CW-1:0] CNT_RCD = CW'(T_RCD - 1);
  localparam logic [CW-1:0] CNT_CL  = CW'(T_CL - 1);
  localparam logic [CW-1:0] CNT_WR  = CW'(T_WR - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CLOSE - 1);
  localparam logic [IW-1:0] IDLE_ONE  = IW'(1);
  localparam logic [IW-1:0] IDLE_ZERO = {IW{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_ACT  = 3'd2,
    S_CAS  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          row_open_q, row_open_d;
  logic [10:0]   open_row_q, open_row_d;
  logic          pend_q, pend_d;
  logic          wr_q, wr_d;
  logic [20:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          csn_q, csn_d;
  logic          rasn_q, rasn_d;
  logic          casn_q, casn_d;
  logic          wen_q, wen_d;
  logic [10:0]   a_q, a_d;
  logic [31:0]   d_q, d_d;

  // Next-state and next-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idle_cnt_d = idle_cnt_q;
    row_open_d = row_open_q;
    open_row_d = open_row_q;
    pend_d     = pend_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;

    case (state_q)
      S_IDLE: begin
        // A request wins over the auto-close decision on the same edge.
        if (bus.req) begin
          wr_d       = bus.write;
          addr_d     = bus.addr;
          wdata_d    = bus.wdata;
          pend_d     = 1'b1;
          idle_cnt_d = IDLE_ZERO;
          if (row_open_q && (open_row_q == bus.addr[20:10])) begin
            state_d = S_CAS;
            cnt_d   = bus.write ? CNT_WR : CNT_CL;
          end else if (row_open_q) begin
            state_d = S_PRE;
            cnt_d   = CNT_RP;
          end else begin
            state_d = S_ACT;
            cnt_d   = CNT_RCD;
          end
        end else if (row_open_q) begin
          if (idle_cnt_q == IDLE_LAST) begin
            idle_cnt_d = IDLE_ZERO;
            state_d    = S_PRE;
            cnt_d      = CNT_RP;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_ONE;
          end
        end else begin
          idle_cnt_d = IDLE_ZERO;
        end
      end
      S_PRE: begin
        // pend_q distinguishes a row miss from an auto-close precharge.
        if (cnt_q == CNT_ZERO) begin
          row_open_d = 1'b0;
          if (pend_q) begin
            state_d = S_ACT;
            cnt_d   = CNT_RCD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_ACT: begin
        if (cnt_q == CNT_ZERO) begin
          row_open_d = 1'b1;
          open_row_d = addr_q[20:10];
          state_d    = S_CAS;
          cnt_d      = wr_q ? CNT_WR : CNT_CL;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_CAS: begin
        if (cnt_q == CNT_ZERO) begin
          // Read data is taken on the edge closing the last CAS cycle.
          if (!wr_q) begin
            rdata_d = DRAM_Q;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    csn_d  = 1'b1;
    rasn_d = 1'b1;
    casn_d = 1'b1;
    wen_d  = 1'b1;
    a_d    = a_q;
    d_d    = d_q;
    case (state_d)
      S_IDLE: begin
        a_d = 11'd0;
        if (row_open_d) begin
          csn_d  = 1'b0;
          rasn_d = 1'b0;
        end else begin
          csn_d  = 1'b1;
          rasn_d = 1'b1;
        end
      end
      S_PRE: begin
        csn_d = 1'b0;
        a_d   = 11'd0;
      end
      S_ACT: begin
        csn_d  = 1'b0;
        rasn_d = 1'b0;
        a_d    = addr_d[20:10];
      end
      S_CAS: begin
        csn_d  = 1'b0;
        rasn_d = 1'b0;
        casn_d = 1'b0;
        wen_d  = ~wr_d;
        a_d    = {1'b0, addr_d[9:0]};
        d_d    = wdata_d;
      end
      S_DONE: begin
        csn_d  = 1'b0;
        rasn_d = 1'b0;
      end
      default: begin
        csn_d = 1'b1;
      end
    endcase
    ack_d  = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      idle_cnt_q <= IDLE_ZERO;
      row_open_q <= 1'b0;
      open_row_q <= 11'd0;
      pend_q     <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= 21'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      csn_q      <= 1'b1;
      rasn_q     <= 1'b1;
      casn_q     <= 1'b1;
      wen_q      <= 1'b1;
      a_q        <= 11'd0;
      d_q        <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idle_cnt_q <= idle_cnt_d;
      row_open_q <= row_open_d;
      open_row_q <= open_row_d;
      pend_q     <= pend_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      csn_q      <= csn_d;
      rasn_q     <= rasn_d;
      casn_q     <= casn_d;
      wen_q      <= wen_d;
      a_q        <= a_d;
      d_q        <= d_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign DRAM_CSn  = csn_q;
  assign DRAM_RASn = rasn_q;
  assign DRAM_CASn = casn_q;
  assign DRAM_WEn  = wen_q;
  assign DRAM_A    = a_q;
  assign DRAM_D    = d_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl -- scoreboard bench for dram_ctrl.
// A DRAM device model answers the strobes; a transaction-level model predicts
// the ack cycle (from row-hit/miss/cold timing and auto-close) and read data.
module tb_dram_ctrl;
  localparam int T_RP = 2, T_RCD = 2, T_CL = 3, T_WR = 2, IDLE_CLOSE = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_ctrl_if bus();
  logic [31:0] dram_q = 32'd0;
  logic csn, rasn, casn, wen;
  logic [10:0] a;
  logic [31:0] d;

  dram_ctrl #(.T_RP(T_RP), .T_RCD(T_RCD), .T_CL(T_CL), .T_WR(T_WR),
              .IDLE_CLOSE(IDLE_CLOSE)) dut (
    .clk(clk), .rst(rst), .bus(bus), .DRAM_Q(dram_q),
    .DRAM_CSn(csn), .DRAM_RASn(rasn), .DRAM_CASn(casn), .DRAM_WEn(wen),
    .DRAM_A(a), .DRAM_D(d)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Content of a never-written DRAM word.
  function automatic logic [31:0] init_word(input logic [20:0] wa);
    return {wa[20:10], wa[9:0], 11'h5A5} ^ 32'hA5C3_0F1E;
  endfunction

  // ---------------- DRAM device model (acts mid-cycle) ----------------
  logic [31:0] dram_mem [logic [20:0]];
  logic [10:0] dram_row = 11'd0;
  logic        rasn_prev = 1'b1;

  always @(negedge clk) begin
    logic [20:0] k;
    if (!csn && !rasn && rasn_prev) dram_row = a;
    rasn_prev = rasn;
    k = {dram_row, a[9:0]};
    if (!casn) chk("cas_strobes", {29'd0, csn, rasn, a[10]}, 32'd0);
    if (!csn && !casn && !wen) dram_mem[k] = d;
    dram_q <= dram_mem.exists(k) ? dram_mem[k] : init_word(k);
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          cyc;
    logic        is_rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ref_mem [logic [20:0]];
  bit          m_open = 1'b0;
  logic [10:0] m_row = 11'd0;
  int          m_last_ack = 0;
  bit          abort = 1'b0;

  // Monitor: every ack must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (bus.ack === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_cycle", cyc, e.cyc);
        if (e.is_rd) chk("rdata", bus.rdata, e.data);
      end
    end
  end

  // Issue one access at the current cycle; returns one cycle after ack with req low.
  task automatic issue(input logic w, input logic [20:0] ad, input logic [31:0] wd);
    int s, nacc, lat;
    bit hit, miss, got;
    exp_t e;
    s = cyc;
    bus.req = 1'b1; bus.write = w; bus.addr = ad; bus.wdata = wd;
    nacc = s;
    if (m_open && (s - m_last_ack > IDLE_CLOSE)) begin
      m_open = 1'b0;
      if (m_last_ack + IDLE_CLOSE + T_RP + 1 > s) nacc = m_last_ack + IDLE_CLOSE + T_RP + 1;
    end
    hit  = m_open && (m_row == ad[20:10]);
    miss = m_open && !hit;
    lat  = (w ? T_WR : T_CL) + (hit ? 0 : T_RCD) + (miss ? T_RP : 0);
    e.cyc   = nacc + lat + 1;
    e.is_rd = !w;
    e.data  = w ? 32'd0 : (ref_mem.exists(ad) ? ref_mem[ad] : init_word(ad));
    sb.push_back(e);
    if (w) ref_mem[ad] = wd;
    m_open = 1'b1; m_row = ad[20:10]; m_last_ack = e.cyc;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) got = 1'b1;
      else if (cyc > nacc) begin
        // Bus contents after acceptance must not matter.
        bus.addr = 21'($urandom); bus.wdata = $urandom; bus.write = 1'($urandom);
      end
    end
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
      abort = 1'b1;
    end
    @(posedge clk); #1;
    bus.req = 1'b0;
  endtask

  task automatic gap(input int g);
    repeat (g) begin @(posedge clk); #1; end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_strobes"}, {28'd0, csn, rasn, casn, wen}, 32'hF);
    chk({nm, "_a"}, {21'd0, a}, 32'd0);
    chk({nm, "_d"}, d, 32'd0);
    chk({nm, "_ack_busy"}, {30'd0, bus.ack, bus.busy}, 32'd0);
    chk({nm, "_rdata"}, bus.rdata, 32'd0);
  endtask

  initial begin
    bus.req = 1'b0; bus.write = 1'b0; bus.addr = 21'd0; bus.wdata = 32'd0;
    // Reset for two cycles.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;

    // Cold read row5/col12, hit write, hit read-back, miss read.
    dram_mem[{11'd5, 10'd12}] = 32'h1234_5678;
    ref_mem[{11'd5, 10'd12}]  = 32'h1234_5678;
    issue(1'b0, {11'd5, 10'd12}, 32'd0);
    issue(1'b1, {11'd5, 10'd13}, 32'hDEAD_BEEF);
    issue(1'b0, {11'd5, 10'd13}, 32'd0);
    issue(1'b0, {11'd7, 10'd0}, 32'd0);

    // Auto-close: 16 idle cycles, two PRE cycles, then closed idle.
    gap(16);
    @(negedge clk);
    chk("autoclose_pre1", {28'd0, csn, rasn, casn, wen}, 32'h7);
    @(negedge clk);
    chk("autoclose_pre2", {28'd0, csn, rasn, casn, wen}, 32'h7);
    @(negedge clk);
    chk("autoclose_idle", {28'd0, csn, rasn, casn, wen, bus.busy}, 32'h1E);
    @(posedge clk); #1;
    issue(1'b0, {11'd7, 10'd0}, 32'd0);          // cold again
    gap(15);
    issue(1'b0, {11'd7, 10'd3}, 32'd0);          // same edge as auto-close limit: hit
    gap(16);
    issue(1'b1, {11'd2, 10'd4}, 32'h0BAD_F00D);  // arrives during auto-close PRE
    gap(17);
    issue(1'b0, {11'd2, 10'd4}, 32'd0);

    // Reset in the second CAS cycle of a cold read.
    gap(20);
    bus.req = 1'b1; bus.write = 1'b0; bus.addr = {11'd3, 10'd1};
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(negedge clk);
    chk_reset_vals("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    m_open = 1'b0;
    issue(1'b0, {11'd5, 10'd12}, 32'd0);

    // Randomized traffic over a few rows to mix hits, misses and closes.
    for (int i = 0; i < 40 && !abort; i++) begin
      logic w;
      logic [20:0] ad;
      w  = 1'($urandom);
      ad = {11'($urandom_range(0, 3)), 10'($urandom_range(0, 7))};
      if ($urandom_range(0, 3) == 0) gap($urandom_range(12, 22));
      else gap($urandom_range(0, 3));
      issue(w, ad, $urandom);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
